// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the PIPE power/receiver-detect sequencer:
//   - PIPE PowerDown encodings PD_P0 / PD_P0S / PD_P1 / PD_P2
//   - RXSTAT_DETECTED, the RxStatus code reported for a detected receiver
//   - seq_state_t, the sequencer state enumeration
//   - pd_from_target(), maps the 2-bit LTSSM target onto the 4-bit PowerDown bus
package pipe_pkg;

  localparam logic [3:0] PD_P0  = 4'd0;
  localparam logic [3:0] PD_P0S = 4'd1;
  localparam logic [3:0] PD_P1  = 4'd2;
  localparam logic [3:0] PD_P2  = 4'd3;

  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef enum logic [2:0] {
    RST_WAIT   = 3'd0,
    IDLE       = 3'd1,
    PWR_WAIT   = 3'd2,
    DET_ASSERT = 3'd3,
    DET_WAIT   = 3'd4,
    DET_DONE   = 3'd5
  } seq_state_t;

  function automatic logic [3:0] pd_from_target(input logic [1:0] target);
    return {2'b00, target};
  endfunction

endpackage

// File: rtl/pipe_seq_timer.sv
// pipe_seq_timer
// PhyStatus wait-timeout counter. Exists only when PIPE_SEQ_TIMEOUT_EN is
// defined; the default build has no timer at all.
// Ports:
//   pclk      in  PIPE clock
//   reset_n   in  asynchronous active-low reset
//   i_clear   in  hold the count at zero (sequencer not waiting)
//   i_run     in  sequencer is waiting for PhyStatus; count one per cycle
//   o_expire  out high in the wait cycle at whose end the count reaches
//                 TIMEOUT_CYCLES
`ifdef PIPE_SEQ_TIMEOUT_EN
module pipe_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic pclk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The count reaches TIMEOUT_CYCLES on the edge closing this cycle, so the
  // sequencer leaves the wait on that same edge.
  assign o_expire = i_run && (r_cnt == CNT_LAST);

endmodule
`endif

// File: rtl/pipe_power_sequencer.sv
// pipe_power_sequencer
// Sequences PIPE power-state changes and receiver detection for all lanes in
// lockstep on behalf of the LTSSM. Each request is completed on the PHY's
// shared PhyStatus handshake and acknowledged with a one-cycle done pulse.
// Optional feature: define PIPE_SEQ_TIMEOUT_EN to abort a PhyStatus wait
// after TIMEOUT_CYCLES cycles (seq_error pulse plus the matching done pulse).
// Ports:
//   pclk, reset_n        PIPE clock, asynchronous active-low reset
//   pwr_req, pwr_target  level power-change request and target (0=P0..3=P2)
//   det_req              level receiver-detect request
//   elecidle_req         LTSSM transmitter electrical-idle request
//   PhyStatus, RxStatus  PHY completion strobe and per-lane status (3b/lane)
//   PowerDown, TxDetectRx_Loopback, TxElecIdle   PIPE controls to the PHY
//   busy                 sequencer not in IDLE
//   pwr_done, det_done   one-cycle completion pulses
//   det_result           per-lane receiver present, valid from det_done
//   seq_error            one-cycle timeout pulse (tied 0 without the timer)
module pipe_power_sequencer
  import pipe_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   pwr_req,
  input  logic [1:0]             pwr_target,
  input  logic                   det_req,
  input  logic                   elecidle_req,
  input  logic                   PhyStatus,
  input  logic [3*NUM_LANES-1:0] RxStatus,
  output logic [3:0]             PowerDown,
  output logic                   TxDetectRx_Loopback,
  output logic                   TxElecIdle,
  output logic                   busy,
  output logic                   pwr_done,
  output logic                   det_done,
  output logic [NUM_LANES-1:0]   det_result,
  output logic                   seq_error
);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [3:0]             r_powerdown,  w_powerdown_nxt;
  logic                   r_txdet,      w_txdet_nxt;
  logic                   r_pwr_done,   w_pwr_done_nxt;
  logic                   r_det_done,   w_det_done_nxt;
  logic                   r_seq_error,  w_seq_error_nxt;
  logic                   r_det_pend,   w_det_pend_nxt;
  logic [NUM_LANES-1:0]   r_det_result, w_det_result_nxt;
  logic                   r_eidle;
  logic [NUM_LANES-1:0]   w_det_hit;
  logic [3:0]             w_target_pd;
  logic                   w_waiting;
  logic                   w_done_out;
  logic                   w_tmo_expire;

  assign w_target_pd = pd_from_target(pwr_target);
  assign w_waiting   = (r_state == PWR_WAIT) || (r_state == DET_WAIT);
  // A requester only drops its level request after seeing done, so no new
  // request is taken while a done pulse is on the outputs.
  assign w_done_out  = r_pwr_done || r_det_done;

  always_comb begin
    w_det_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_det_hit[i] = (RxStatus[3*i +: 3] == RXSTAT_DETECTED);
    end
  end

`ifdef PIPE_SEQ_TIMEOUT_EN
  pipe_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .i_clear  (!w_waiting),
    .i_run    (w_waiting),
    .o_expire (w_tmo_expire)
  );
`else
  // Without the timer a PhyStatus wait never expires; the parameter stays
  // referenced so both builds share one parameter list.
  assign w_tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RST_WAIT: begin
        if (!PhyStatus) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (!w_done_out) begin
          if (det_req) begin
            w_state_nxt = (r_powerdown == PD_P1) ? DET_ASSERT : PWR_WAIT;
          end else if (pwr_req && (w_target_pd != r_powerdown)) begin
            w_state_nxt = PWR_WAIT;
          end
        end
      end
      PWR_WAIT: begin
        if (PhyStatus) begin
          w_state_nxt = r_det_pend ? DET_ASSERT : IDLE;
        end else if (w_tmo_expire) begin
          w_state_nxt = IDLE;
        end
      end
      DET_ASSERT: w_state_nxt = DET_WAIT;
      DET_WAIT: begin
        if (PhyStatus) begin
          w_state_nxt = DET_DONE;
        end else if (w_tmo_expire) begin
          w_state_nxt = IDLE;
        end
      end
      DET_DONE: w_state_nxt = IDLE;
      default:  w_state_nxt = RST_WAIT;
    endcase
  end

  // Output logic: next values of the registered PIPE controls and pulses
  always_comb begin
    w_powerdown_nxt  = r_powerdown;
    w_txdet_nxt      = r_txdet;
    w_det_result_nxt = r_det_result;
    w_det_pend_nxt   = r_det_pend;
    w_pwr_done_nxt   = 1'b0;
    w_det_done_nxt   = 1'b0;
    w_seq_error_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_done_out) begin
          if (det_req) begin
            // Detect only runs from P1; get there first without pwr_done.
            if (r_powerdown != PD_P1) begin
              w_powerdown_nxt = PD_P1;
              w_det_pend_nxt  = 1'b1;
            end else begin
              w_txdet_nxt = 1'b1;
            end
          end else if (pwr_req) begin
            if (w_target_pd == r_powerdown) begin
              w_pwr_done_nxt = 1'b1;
            end else begin
              w_powerdown_nxt = w_target_pd;
            end
          end
        end
      end
      PWR_WAIT: begin
        if (PhyStatus) begin
          if (r_det_pend) begin
            w_txdet_nxt    = 1'b1;
            w_det_pend_nxt = 1'b0;
          end else begin
            w_pwr_done_nxt = 1'b1;
          end
        end else if (w_tmo_expire) begin
          w_seq_error_nxt = 1'b1;
          if (r_det_pend) begin
            w_det_pend_nxt   = 1'b0;
            w_det_done_nxt   = 1'b1;
            w_det_result_nxt = '0;
          end else begin
            w_pwr_done_nxt = 1'b1;
          end
        end
      end
      DET_WAIT: begin
        if (PhyStatus) begin
          w_txdet_nxt      = 1'b0;
          w_det_done_nxt   = 1'b1;
          w_det_result_nxt = w_det_hit;
        end else if (w_tmo_expire) begin
          w_seq_error_nxt  = 1'b1;
          w_txdet_nxt      = 1'b0;
          w_det_done_nxt   = 1'b1;
          w_det_result_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_powerdown  <= PD_P1;
      r_txdet      <= 1'b0;
      r_pwr_done   <= 1'b0;
      r_det_done   <= 1'b0;
      r_seq_error  <= 1'b0;
      r_det_pend   <= 1'b0;
      r_det_result <= '0;
      r_eidle      <= 1'b1;
    end else begin
      r_powerdown  <= w_powerdown_nxt;
      r_txdet      <= w_txdet_nxt;
      r_pwr_done   <= w_pwr_done_nxt;
      r_det_done   <= w_det_done_nxt;
      r_seq_error  <= w_seq_error_nxt;
      r_det_pend   <= w_det_pend_nxt;
      r_det_result <= w_det_result_nxt;
      r_eidle      <= elecidle_req;
    end
  end

  assign PowerDown           = r_powerdown;
  assign TxDetectRx_Loopback = r_txdet;
  assign busy                = (r_state != IDLE);
  assign pwr_done            = r_pwr_done;
  assign det_done            = r_det_done;
  assign det_result          = r_det_result;
  assign seq_error           = r_seq_error;
  // The LTSSM controls electrical idle only in P0/P0s outside a detect.
  assign TxElecIdle = (((r_powerdown == PD_P0) || (r_powerdown == PD_P0S)) &&
                       (r_state != DET_ASSERT) && (r_state != DET_WAIT)) ?
                      r_eidle : 1'b1;

endmodule

// File: tb/tb_pipe_power_sequencer.sv
module tb_pipe_power_sequencer;

  localparam int NL = 4;
`ifdef PIPE_SEQ_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  logic            pclk = 1'b0;
  logic            reset_n;
  logic            pwr_req;
  logic [1:0]      pwr_target;
  logic            det_req;
  logic            elecidle_req;
  logic            PhyStatus;
  logic [3*NL-1:0] RxStatus;
  logic [3:0]      PowerDown;
  logic            TxDetectRx_Loopback;
  logic            TxElecIdle;
  logic            busy;
  logic            pwr_done;
  logic            det_done;
  logic [NL-1:0]   det_result;
  logic            seq_error;

  int            n_chk  = 0;
  int            n_pass = 0;
  int            model_pd;
  logic [NL-1:0] model_res;

  pipe_power_sequencer #(
    .NUM_LANES      (NL),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .pclk                (pclk),
    .reset_n             (reset_n),
    .pwr_req             (pwr_req),
    .pwr_target          (pwr_target),
    .det_req             (det_req),
    .elecidle_req        (elecidle_req),
    .PhyStatus           (PhyStatus),
    .RxStatus            (RxStatus),
    .PowerDown           (PowerDown),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .TxElecIdle          (TxElecIdle),
    .busy                (busy),
    .pwr_done            (pwr_done),
    .det_done            (det_done),
    .det_result          (det_result),
    .seq_error           (seq_error)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge pclk);
  endtask

  // Receiver present on a lane exactly when its RxStatus code is 3.
  function automatic logic [NL-1:0] expect_detect(input logic [3*NL-1:0] rx);
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = (((rx >> (3 * i)) & 7) == 3);
    return r;
  endfunction

  function automatic logic [3*NL-1:0] rand_rx();
    logic [3*NL-1:0] rx;
    for (int i = 0; i < NL; i++) begin
      rx[3*i +: 3] = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
    end
    return rx;
  endfunction

  task automatic check_idle_eidle(input logic e);
    elecidle_req = e;
    tick();
    chk("eidle", TxElecIdle, (model_pd <= 1) ? e : 1'b1);
  endtask

  // Power change: request in cycle N, PhyStatus in cycle N+dly.
  task automatic do_pwr(input logic [1:0] tgt, input int dly);
    pwr_req    = 1'b1;
    pwr_target = tgt;
    tick();
    if (int'(tgt) == model_pd) begin
      chk("noop_done", pwr_done, 1);
      chk("noop_busy", busy, 0);
      chk("noop_pd", PowerDown, tgt);
      pwr_req = 1'b0;
      tick();
      chk("noop_done_clr", pwr_done, 0);
    end else begin
      chk("pwr_pd", PowerDown, tgt);
      chk("pwr_busy", busy, 1);
      for (int i = 1; i < dly; i++) begin
        tick();
        chk("pwr_wait_done", pwr_done, 0);
      end
      PhyStatus = 1'b1;
      tick();
      PhyStatus = 1'b0;
      chk("pwr_done", pwr_done, 1);
      chk("pwr_busy_clr", busy, 0);
      pwr_req = 1'b0;
      tick();
      chk("pwr_done_clr", pwr_done, 0);
      model_pd = int'(tgt);
    end
    chk("pwr_pd_final", PowerDown, model_pd);
  endtask

  // Receiver detect; leaves pwr_req untouched so a concurrent request can wait.
  task automatic do_det(input logic [3*NL-1:0] rx, input int dly);
    logic [NL-1:0] exp;
    exp     = expect_detect(rx);
    det_req = 1'b1;
    tick();
    if (model_pd != 2) begin
      chk("det_pd_p1", PowerDown, 2);
      chk("det_pre_txdet", TxDetectRx_Loopback, 0);
      chk("det_pre_busy", busy, 1);
      for (int i = 1; i < dly; i++) tick();
      PhyStatus = 1'b1;
      tick();
      PhyStatus = 1'b0;
      chk("det_no_pwr_done", pwr_done, 0);
    end
    chk("det_assert_txdet", TxDetectRx_Loopback, 1);
    chk("det_assert_eidle", TxElecIdle, 1);
    chk("det_assert_busy", busy, 1);
    tick();
    for (int i = 1; i < dly; i++) begin
      RxStatus = 12'($urandom);
      tick();
    end
    chk("det_wait_txdet", TxDetectRx_Loopback, 1);
    RxStatus  = rx;
    PhyStatus = 1'b1;
    tick();
    PhyStatus = 1'b0;
    RxStatus  = 12'($urandom);
    chk("det_done", det_done, 1);
    chk("det_result", det_result, exp);
    chk("det_txdet_drop", TxDetectRx_Loopback, 0);
    det_req = 1'b0;
    tick();
    chk("det_done_clr", det_done, 0);
    chk("det_busy_clr", busy, 0);
    chk("det_pd_stay", PowerDown, 2);
    chk("det_result_hold", det_result, exp);
    model_pd  = 2;
    model_res = exp;
  endtask

  initial begin
    reset_n      = 1'b0;
    pwr_req      = 1'b0;
    pwr_target   = 2'd0;
    det_req      = 1'b0;
    elecidle_req = 1'b0;
    PhyStatus    = 1'b1;
    RxStatus     = '0;
    model_pd     = 2;
    model_res    = '0;

    // Reset values, then RST_WAIT holds until PhyStatus drops.
    repeat (3) tick();
    chk("rst_pd", PowerDown, 2);
    chk("rst_txdet", TxDetectRx_Loopback, 0);
    chk("rst_eidle", TxElecIdle, 1);
    chk("rst_busy", busy, 1);
    chk("rst_pwr_done", pwr_done, 0);
    chk("rst_det_done", det_done, 0);
    chk("rst_det_result", det_result, 0);
    chk("rst_seq_error", seq_error, 0);
    reset_n = 1'b1;
    pwr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstwait_busy", busy, 1);
      chk("rstwait_pd", PowerDown, 2);
      chk("rstwait_eidle", TxElecIdle, 1);
    end
    pwr_req   = 1'b0;
    PhyStatus = 1'b0;
    tick();
    chk("rstwait_exit_busy", busy, 0);
    chk("rstwait_no_done", pwr_done, 0);

    // Directed flows.
    do_pwr(2'd0, 4);
    check_idle_eidle(1'b0);
    check_idle_eidle(1'b1);
    do_det(12'b011_011_000_011, 3);
    chk("det_dir_1101", det_result, 4'b1101);
    check_idle_eidle(1'b0);

    // Concurrent detect and power request: detect goes first.
    pwr_req    = 1'b1;
    pwr_target = 2'd3;
    do_det(rand_rx(), 2);
    chk("both_no_pwr_done", pwr_done, 0);
    do_pwr(2'd3, 3);

    // Stray PhyStatus in IDLE is ignored.
    PhyStatus = 1'b1;
    tick();
    PhyStatus = 1'b0;
    tick();
    chk("stray_busy", busy, 0);
    chk("stray_pwr_done", pwr_done, 0);
    chk("stray_det_done", det_done, 0);
    chk("stray_pd", PowerDown, model_pd);

    // Randomized mix of transactions.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: do_pwr(2'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        1: do_det(rand_rx(), int'($urandom_range(1, 6)));
        default: check_idle_eidle(1'($urandom_range(0, 1)));
      endcase
      chk("rand_seq_error", seq_error, 0);
    end

`ifdef PIPE_SEQ_TIMEOUT_EN
    // Detect with no PhyStatus: abort after TB_TMO wait cycles.
    do_det({NL{3'b011}}, 1);
    det_req = 1'b1;
    tick();
    tick();
    for (int i = 1; i < TB_TMO; i++) begin
      tick();
      chk("tmo_wait_err", seq_error, 0);
    end
    chk("tmo_wait_txdet", TxDetectRx_Loopback, 1);
    tick();
    chk("tmo_seq_error", seq_error, 1);
    chk("tmo_det_done", det_done, 1);
    chk("tmo_det_result", det_result, 0);
    chk("tmo_txdet", TxDetectRx_Loopback, 0);
    chk("tmo_pd", PowerDown, 2);
    det_req = 1'b0;
    tick();
    chk("tmo_err_clr", seq_error, 0);
    chk("tmo_done_clr", det_done, 0);
`else
    chk("no_timer_seq_error", seq_error, 0);
`endif

    // Reset asserted in DET_WAIT.
    do_det({NL{3'b011}}, 1);
    det_req = 1'b1;
    tick();
    tick();
    chk("rstmid_txdet_before", TxDetectRx_Loopback, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_pd", PowerDown, 2);
    chk("rstmid_txdet", TxDetectRx_Loopback, 0);
    chk("rstmid_eidle", TxElecIdle, 1);
    chk("rstmid_busy", busy, 1);
    chk("rstmid_det_result", det_result, 0);
    PhyStatus = 1'b1;
    RxStatus  = {NL{3'b011}};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_det_done", det_done, 0);
    end
    det_req   = 1'b0;
    PhyStatus = 1'b0;
    reset_n   = 1'b1;
    tick();
    chk("rstmid_exit_busy", busy, 0);
    chk("rstmid_exit_det_done", det_done, 0);
    chk("rstmid_exit_result", det_result, 0);
    model_pd  = 2;
    model_res = '0;
    do_pwr(2'd1, 2);
    check_idle_eidle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_power_sequencer.md
Name: pipe_power_sequencer

Overview:
- Sequences the PIPE power-state and receiver-detect handshakes for all lanes of the link on behalf of the LTSSM.
- Accepts power-change and receiver-detect requests, drives PowerDown / TxDetectRx_Loopback / TxElecIdle, and completes each request on the PHY's PhyStatus handshake.
- Returns a per-lane detect result.
- Sits between the LTSSM and the PHY, replacing ad-hoc per-state PIPE control logic.

Parameters:
- NUM_LANES, 4, number of PIPE lanes sequenced in lockstep.
- TIMEOUT_CYCLES, 1024, pclk cycles to wait for PhyStatus before aborting; used only with PIPE_SEQ_TIMEOUT_EN.

Ports:
- pclk  in  1  PIPE clock.
- reset_n  in  1  asynchronous, active-low reset.
- pwr_req  in  1  level request to change power state; held until pwr_done.
- pwr_target  in  2  requested state: 0=P0, 1=P0s, 2=P1, 3=P2; stable while pwr_req is high.
- det_req  in  1  level request for receiver detect; held until det_done.
- elecidle_req  in  1  LTSSM request for transmitter electrical idle.
- PhyStatus  in  1  PHY completion/status strobe (shared across lanes).
- RxStatus  in  3*NUM_LANES  per-lane RxStatus; lane i occupies bits [3i+2:3i].
- PowerDown  out  4  PIPE PowerDown.
- TxDetectRx_Loopback  out  1  PIPE detect/loopback control.
- TxElecIdle  out  1  PIPE transmitter electrical idle.
- busy  out  1  high whenever the state machine is not in IDLE.
- pwr_done  out  1  one-cycle completion pulse for a power change.
- det_done  out  1  one-cycle completion pulse for a receiver detect.
- det_result  out  NUM_LANES  bit i = receiver present on lane i; valid from det_done until the next detect.
- seq_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values:
  - PowerDown=4'b0010 (P1), TxDetectRx_Loopback=0, TxElecIdle=1, busy=1.
  - pwr_done=0, det_done=0, det_result=0, seq_error=0.
  - State=RST_WAIT.
- RST_WAIT:
  - Waits for PhyStatus=0 (PHY clock stable), then moves to IDLE.
  - Requests are not accepted in this state.
- IDLE:
  - busy=0.
  - Priority: det_req over pwr_req.
  - A request is accepted in the cycle it is sampled high. busy rises the next cycle.
- Power change:
  - If the request is accepted at cycle N, PowerDown takes pwr_target at N+1 and the state becomes PWR_WAIT.
  - PWR_WAIT holds until PhyStatus=1 is sampled. pwr_done pulses the following cycle, then the state returns to IDLE.
  - If pwr_target equals the current state, pwr_done pulses at N+1 without any PIPE change.
- Receiver detect:
  - If current state is not P1, run the power sequence to P1 first, with no pwr_done. Then enter DET_ASSERT.
  - DET_ASSERT: TxDetectRx_Loopback=1, TxElecIdle forced to 1. Next state is DET_WAIT.
  - DET_WAIT: on PhyStatus=1, capture det_result[i] = (RxStatus lane i == 3'b011) and drop TxDetectRx_Loopback in the same cycle.
  - The next cycle is DET_DONE: det_done pulses, then IDLE.
  - PowerDown stays at P1 after a detect.
- TxElecIdle:
  - Equals registered elecidle_req (one-cycle latency) in P0/P0s outside detect.
  - Forced to 1 in P1/P2 and during DET_ASSERT/DET_WAIT.
- Protocol rules:
  - A PhyStatus pulse outside a wait state is ignored.
  - A requester that drops its req before done is a protocol violation. The sequence still completes and the done pulse is still issued.
- det_req and pwr_req high together in IDLE: detect is serviced first. pwr_req is serviced after returning to IDLE if still high.
- Reset asserted mid-operation: immediate return to reset values. The in-flight request gets no done pulse.

Optional Feature:
- Macro: PIPE_SEQ_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to PWR_WAIT or DET_WAIT and increments each cycle while waiting.
  - On reaching TIMEOUT_CYCLES: seq_error pulses, TxDetectRx_Loopback=0, det_result=0.
  - The matching done pulse is issued in the same cycle as seq_error, and the state returns to IDLE.
  - PowerDown keeps the last driven value.
- When undefined: waits are unbounded and seq_error is tied 0.

Decomposition:
- Shared package pipe_pkg:
  - Power-state constants PD_P0/PD_P0S/PD_P1/PD_P2.
  - RXSTAT_DETECTED=3'b011.
  - Sequencer state enum (RST_WAIT, IDLE, PWR_WAIT, DET_ASSERT, DET_WAIT, DET_DONE).
- One natural sub-module: pipe_seq_timer (load/clear/expire counter), instantiated only under PIPE_SEQ_TIMEOUT_EN.

Test Plan:
- Reset with PhyStatus=1, release reset, drop PhyStatus after 5 cycles -> busy stays 1 until PhyStatus=0, then 0; PowerDown=2 and TxElecIdle=1 throughout.
- pwr_req with pwr_target=0 in IDLE; PhyStatus pulse 4 cycles later -> PowerDown=0 at N+1, pwr_done exactly one cycle after PhyStatus, busy cleared.
- From P0, det_req with RxStatus lanes=011,000,011,011 on PhyStatus -> PowerDown goes to 2 first, then TxDetectRx_Loopback=1, det_result=4'b1101, det_done pulses, PowerDown stays 2.
- det_req and pwr_req (target 3) raised in the same cycle -> detect completes first (det_done), then PowerDown=3 and pwr_done.
- With PIPE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, det_req with PhyStatus never asserted -> seq_error and det_done at the 16th wait cycle, det_result=0, TxDetectRx_Loopback=0.
- reset_n asserted during DET_WAIT -> all outputs return to reset values asynchronously; no det_done pulse.
